// File: rtl/ripple_down_counter.sv
// Ripple (asynchronous) binary down counter built from a T flip-flop chain, with a combinational zero flag.
// Define SYNC_OUT_EN to drive Q and zero from a CLK-synchronous copy of the chain. This removes glitches and adds one cycle of latency.
`timescale 1ns/1ps

module ripple_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             en,
  output logic [WIDTH-1:0] Q,
  output logic             zero
);

  logic [WIDTH-1:0] chain;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_stage
      logic bit_q;
      logic bit_d;

      if (i == 0) begin : g_lsb
        always_comb begin
          bit_d = bit_q;
          if (en) bit_d = ~bit_q;
        end

        always_ff @(posedge CLK or negedge Reset) begin
          if (!Reset) bit_q <= 1'b0;
          else        bit_q <= bit_d;
        end
      end else begin : g_upper
        // A 0->1 edge on the bit below is a borrow, so this stage toggles on the rising edge of that bit.
        always_comb bit_d = ~bit_q;

        always_ff @(posedge chain[i-1] or negedge Reset) begin
          if (!Reset) bit_q <= 1'b0;
          else        bit_q <= bit_d;
        end
      end

      assign chain[i] = bit_q;
    end
  endgenerate

`ifdef SYNC_OUT_EN
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;

  // Samples the chain on the same edge that starts the next ripple.
  // This always captures the value that has settled since the previous edge.
  always_comb out_d = chain;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) out_q <= '0;
    else        out_q <= out_d;
  end

  assign Q = out_q;
`else
  assign Q = chain;
`endif

  assign zero = (Q == '0);

endmodule

// File: tb/tb_ripple_down_counter.sv
// Scoreboard bench for ripple_down_counter: 4-bit and 6-bit instances driven by directed vectors.
// When SYNC_OUT_EN is defined, expectations are delayed one cycle to match the output register.
`timescale 1ns/1ps

module tb_ripple_down_counter;

  typedef struct {
    int         dut;
    logic [7:0] q;
    logic       z;
    string      name;
  } exp_t;

  logic       CLK = 1'b0;
  logic       R4, R6, en4, en6;
  logic [3:0] Q4;
  logic [5:0] Q6;
  logic       zero4, zero6;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   z6_hits = 0;
  int   prev[2] = '{0, 0};
  event sample_now;

  int t2[17] = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 15};
  int t3[5]  = '{14, 13, 12, 11, 10};

  ripple_down_counter #(.WIDTH(4)) u4 (
    .CLK(CLK), .Reset(R4), .en(en4), .Q(Q4), .zero(zero4)
  );

  ripple_down_counter #(.WIDTH(6)) u6 (
    .CLK(CLK), .Reset(R6), .en(en6), .Q(Q6), .zero(zero6)
  );

  always #10 CLK = ~CLK;

  task automatic exp_push(input int dut, input int v, input string name, input bit rst);
    exp_t e;
    int   shown;
`ifdef SYNC_OUT_EN
    if (rst) begin
      shown     = 0;
      prev[dut] = 0;
    end else begin
      shown     = prev[dut];
      prev[dut] = v;
    end
`else
    shown = v;
`endif
    e.dut  = dut;
    e.q    = 8'(shown);
    e.z    = (shown == 0);
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic edge_push(input int dut, input int v, input string name, input bit rst);
    @(posedge CLK);
    #1;
    exp_push(dut, v, name, rst);
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  // Monitor: drains the scoreboard at each falling edge or on an explicit mid-cycle sample request.
  initial begin
    forever begin
      exp_t       e;
      logic [7:0] act_q;
      logic       act_z;
      @(negedge CLK or sample_now);
      while (sb.size() > 0) begin
        e     = sb.pop_front();
        act_q = (e.dut == 0) ? {4'b0, Q4} : {2'b0, Q6};
        act_z = (e.dut == 0) ? zero4 : zero6;
        n_cmp++;
        if (e.name == "wrap6" && act_z === 1'b1) z6_hits++;
        if (act_q !== e.q || act_z !== e.z) begin
          n_bad++;
          $display("FAIL %s @%0t: got Q=%0d zero=%b, want Q=%0d zero=%b",
                   e.name, $time, act_q, act_z, e.q, e.z);
        end
      end
    end
  end

  initial begin
    R4 = 1'b0; R6 = 1'b0; en4 = 1'b1; en6 = 1'b1;

    // Reset state, before any clock edge.
    #5;
    exp_push(0, 0, "rst4", 1'b1);
    exp_push(1, 0, "rst6", 1'b1);
    ->sample_now;
    #10 R4 = 1'b1;

    // Count down through a full cycle and wrap.
    for (int k = 0; k < 17; k++) edge_push(0, t2[k], "count", 1'b0);
    for (int k = 0; k < 5; k++)  edge_push(0, t3[k], "to10", 1'b0);

    // Hold for three edges at 1010, then resume.
    en4 = 1'b0;
    for (int k = 0; k < 3; k++) edge_push(0, 10, "hold", 1'b0);
    en4 = 1'b1;
    edge_push(0, 9, "resume", 1'b0);
    edge_push(0, 8, "cnt8", 1'b0);
    edge_push(0, 7, "cnt7", 1'b0);
    edge_push(0, 6, "cnt6", 1'b0);

    // Asynchronous reset between edges at 0110.
    #14 R4 = 1'b0;
    #2;
    exp_push(0, 0, "async_clr", 1'b1);
    ->sample_now;
    edge_push(0, 0, "rst_hold", 1'b1);
    #14 R4 = 1'b1;
    edge_push(0, 15, "post_rel", 1'b0);
    edge_push(0, 14, "post_rel2", 1'b0);

    // 6-bit instance: 64 edges from reset, wrapping to zero exactly once.
    #14 R6 = 1'b1;
    for (int k = 1; k <= 64; k++) edge_push(1, 64 - k, "wrap6", 1'b0);
    edge_push(1, 63, "wrap6", 1'b0);
    edge_push(1, 62, "after_wrap6", 1'b0);

    @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries unchecked, want 0", sb.size());
    end
    n_cmp++;
    if (z6_hits != 1) begin
      n_bad++;
      $display("FAIL wrap6_count: zero seen %0d times, want 1", z6_hits);
    end
    summary();
    $finish;
  end

  initial begin
    #50000;
    n_bad++;
    $display("FAIL watchdog: time limit reached, want completion");
    summary();
    $finish;
  end

endmodule
